interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of level-high interrupt sources (2..8).
REQ-002 SHALL have parameter ID_W, default 2, source-ID width, equal to clog2(NUM_IRQ).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port addr, input, 16 bits: register byte address.
REQ-006 SHALL have port data_in, input, 32 bits: write data.
REQ-007 SHALL have port data_out, output, 32 bits: registered read data, valid one cycle after read_enable.
REQ-008 SHALL have ports write_enable and read_enable, input, 1 bit each: bus strobes; read wins if both are high.
REQ-009 SHALL have port ready, output, 1 bit: constant 1.
REQ-010 SHALL have port irq_in, input, NUM_IRQ bits: source requests; bit 0 is the timer interrupt.
REQ-011 SHALL have port irq_ack, output, NUM_IRQ bits: one-cycle registered acknowledge pulse, one-hot, wired to each source's interrupt_ack.
REQ-012 SHALL have port cpu_irq, output, 1 bit: interrupt request to CPU.
REQ-013 SHALL have port cpu_irq_id, output, ID_W bits: ID of the request currently asserted or in service.

Function
REQ-014 SHALL register irq_in into pending_q every cycle; effective request = pending_q & enable_q.
REQ-015 SHALL use this register map; other addresses read 0 and ignore writes.
- 0x00 PENDING: RO, pending_q.
- 0x04 ENABLE: RW, NUM_IRQ bits.
- 0x08 CLAIM: RO, bit31 valid, ID in [ID_W-1:0].
- 0x0C EOI: WO, data_in[ID_W-1:0] = ID.
- 0x10 STATUS: RO, [1:0] state, [15:8] current ID.
- 0x14 SERVICED: RO, 16-bit count of completed acknowledges, wraps 0xFFFF to 0.
REQ-016 SHALL implement FSM IDLE, ASSERT, SERVICE, ACK, HOLD, encoded 0..4; STATUS[1:0] reports the encoding modulo 4, with HOLD reported as 3.
REQ-017 SHALL, in IDLE with a nonzero effective request, latch the lowest-index requesting ID into cur_id and move to ASSERT next edge.
REQ-018 SHALL drive cpu_irq high only in ASSERT; cpu_irq_id SHALL equal cur_id.
REQ-019 SHALL keep cur_id frozen in ASSERT, with no re-arbitration on higher-priority arrivals.
REQ-020 SHALL, in ASSERT, return to IDLE with no ack if the cur_id request drops (source low or enable cleared).
REQ-021 SHALL, on a CLAIM read in ASSERT, return {1,cur_id} and move to SERVICE.
REQ-022 SHALL return CLAIM = 0 (valid=0) in any other state, with no state change.
REQ-023 SHALL, on an EOI write in SERVICE with ID == cur_id, move to ACK; EOI with a wrong ID or in another state is ignored.
REQ-024 SHALL, in ACK (exactly one cycle), drive irq_ack[cur_id]=1, increment SERVICED, then move to HOLD.
REQ-025 SHALL stay in HOLD one cycle with arbitration disabled (absorbs the stale pending_q sample), then move to IDLE.
REQ-026 SHALL keep ENABLE writes effective in every state; clearing enable in SERVICE does not abort service.
REQ-027 SHALL give a worst-case latency of 2 cycles from irq_in rise to cpu_irq high.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set: state IDLE, cur_id 0, pending_q 0, ENABLE 0x1 (timer enabled), SERVICED 0, data_out 0, irq_ack 0, cpu_irq 0.
REQ-029 SHALL, on reset mid-service, emit no irq_ack pulse and lose the in-service claim.

Structure
REQ-030 SHALL place register address constants and FSM state encodings in shared package/include intc_pkg.
REQ-031 SHALL place the fixed-priority lowest-index-wins selector in sub-module intc_priority_encoder (request vector in; valid and ID out).

Verification
REQ-032 SHALL cover timer loop: timer_peripheral on irq_in[0] (0x0F reload) -> cpu_irq rises ≤2 cycles after interrupt; CLAIM=0x80000000; EOI 0 -> irq_ack[0] one cycle, timer interrupt low, SERVICED=1, no re-trigger.
REQ-033 SHALL cover priority: ENABLE=0xF, irq_in=0b1010 simultaneously -> CLAIM=0x80000001; after EOI 1, next CLAIM=0x80000003.
REQ-034 SHALL cover withdrawal: irq_in[2] pulses 3 cycles, no claim -> cpu_irq returns low, irq_ack stays 0, state IDLE.
REQ-035 SHALL cover bad EOI: in SERVICE with ID 1, EOI 2 -> no ack, STATUS[1:0]=2; then EOI 1 -> ack on bit 1.
REQ-036 SHALL cover reset mid-SERVICE: reset_n low -> all outputs 0 and ENABLE=0x1 immediately; no irq_ack pulse.
REQ-037 SHALL cover wrap: preload 0xFFFF completions -> next ack sets SERVICED=0x0000.

Source files
------------

// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intc_pkg
// Purpose  : Shared definitions for the interrupt controller: register byte
//            addresses, FSM state encoding and the STATUS state-code helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package intc_pkg;

  localparam logic [15:0] C_ADDR_PENDING  = 16'h0000;
  localparam logic [15:0] C_ADDR_ENABLE   = 16'h0004;
  localparam logic [15:0] C_ADDR_CLAIM    = 16'h0008;
  localparam logic [15:0] C_ADDR_EOI      = 16'h000C;
  localparam logic [15:0] C_ADDR_STATUS   = 16'h0010;
  localparam logic [15:0] C_ADDR_SERVICED = 16'h0014;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_SERVICE = 3'd2,
    ST_ACK     = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // STATUS only has two bits for the state; HOLD (4) is folded onto 3.
  function automatic logic [1:0] status_code(state_t s);
    logic [2:0] v;
    v = s;
    return (s == ST_HOLD) ? 2'd3 : v[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : intc_priority_encoder
// Purpose  : Fixed-priority selector; the lowest-index active request wins.
// Ports    : req   - request vector (NUM_IRQ bits)
//            valid - at least one request active
//            id    - index of the winning request (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module intc_priority_encoder
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Level-sensitive interrupt controller with claim/EOI handshake,
//            one-hot acknowledge pulse and a serviced-interrupt counter.
// Ports    : clk, reset_n            - clock, async active-low reset
//            addr, data_in           - register byte address / write data
//            write_enable/read_enable- bus strobes (read wins)
//            data_out, ready         - registered read data, always ready
//            irq_in, irq_ack         - source requests / ack pulses
//            cpu_irq, cpu_irq_id     - request to CPU and its source ID
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic               write_enable,
  input  logic               read_enable,
  output logic               ready,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    cpu_irq_id
);

  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_enable;
  state_t             r_state;
  logic [ID_W-1:0]    r_cur_id;
  logic [15:0]        r_serviced;

  logic [NUM_IRQ-1:0] w_eff;
  logic               w_sel_valid;
  logic [ID_W-1:0]    w_sel_id;
  logic               w_wr;
  logic               w_claim_rd;
  logic               w_eoi_hit;
  logic               w_cur_req;
  logic [31:0]        w_rdata;
  logic               w_unused;

  // A simultaneous read suppresses the write.
  assign w_wr       = write_enable & ~read_enable;
  assign w_eff      = r_pending & r_enable;
  assign w_claim_rd = read_enable && (addr == C_ADDR_CLAIM);
  assign w_eoi_hit  = w_wr && (addr == C_ADDR_EOI) && (data_in[ID_W-1:0] == r_cur_id);
  assign w_cur_req  = w_eff[r_cur_id];
  assign w_unused   = ^data_in[31:NUM_IRQ];

  assign ready      = 1'b1;
  assign cpu_irq_id = r_cur_id;

  intc_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (w_eff),
    .valid (w_sel_valid),
    .id    (w_sel_id)
  );

  always_comb begin
    w_rdata = 32'h0;
    case (addr)
      C_ADDR_PENDING:  w_rdata = 32'(r_pending);
      C_ADDR_ENABLE:   w_rdata = 32'(r_enable);
      C_ADDR_CLAIM:    w_rdata = (r_state == ST_ASSERT) ? {1'b1, 31'(r_cur_id)} : 32'h0;
      C_ADDR_STATUS:   w_rdata = {16'h0, 8'(r_cur_id), 6'h0, status_code(r_state)};
      C_ADDR_SERVICED: w_rdata = {16'h0, r_serviced};
      default:         w_rdata = 32'h0;
    endcase
  end

  // Source sampling, enable register and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_enable  <= NUM_IRQ'(1);
      data_out  <= 32'h0;
    end else begin
      r_pending <= irq_in;
      if (w_wr && (addr == C_ADDR_ENABLE)) begin
        r_enable <= data_in[NUM_IRQ-1:0];
      end
      if (read_enable) begin
        data_out <= w_rdata;
      end
    end
  end

  // Service FSM with registered cpu_irq / irq_ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cur_id   <= '0;
      r_serviced <= 16'h0;
      cpu_irq    <= 1'b0;
      irq_ack    <= '0;
    end else begin
      cpu_irq <= 1'b0;
      irq_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_cur_id <= w_sel_id;
            cpu_irq  <= 1'b1;
            r_state  <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // A claim takes priority over a same-cycle request drop.
          if (w_claim_rd) begin
            r_state <= ST_SERVICE;
          end else if (!w_cur_req) begin
            r_state <= ST_IDLE;
          end else begin
            cpu_irq <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (w_eoi_hit) begin
            irq_ack <= NUM_IRQ'(1) << r_cur_id;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_serviced <= r_serviced + 16'd1;
          r_state    <= ST_HOLD;
        end
        // One dead cycle lets the source's cleared level reach r_pending.
        ST_HOLD: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Self-checking bench for interrupt_controller: register tables,
//            timer loop, priority, withdrawal, bad EOI, counter wrap, reset
//            during service and randomized service sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_interrupt_controller;
  import intc_pkg::*;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [15:0]        addr = 16'h0;
  logic [31:0]        data_in = 32'h0;
  logic [31:0]        data_out;
  logic               write_enable = 1'b0;
  logic               read_enable = 1'b0;
  logic               ready;
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               cpu_irq;
  logic [ID_W-1:0]    cpu_irq_id;

  logic [NUM_IRQ-1:0] irq_drv = '0;
  logic               timer_start = 1'b0;
  logic               timer_run = 1'b0;
  logic               timer_irq = 1'b0;
  logic [7:0]         timer_cnt = 8'h0F;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_serviced = 16'h0;

  assign irq_in = irq_drv | {{(NUM_IRQ-1){1'b0}}, timer_irq};

  always #5 clk = ~clk;

  interrupt_controller #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .ready        (ready),
    .irq_in       (irq_in),
    .irq_ack      (irq_ack),
    .cpu_irq      (cpu_irq),
    .cpu_irq_id   (cpu_irq_id)
  );

  // One-shot timer peripheral: reload 0x0F, fire at zero, clear on ack.
  always @(posedge clk) begin
    if (timer_start && !timer_run) begin
      timer_run <= 1'b1;
      timer_cnt <= 8'h0F;
    end else if (timer_run) begin
      if (timer_cnt == 8'h0) begin
        timer_irq <= 1'b1;
        timer_run <= 1'b0;
      end else begin
        timer_cnt <= timer_cnt - 8'd1;
      end
    end
    if (irq_ack[0]) timer_irq <= 1'b0;
  end

  typedef struct {
    logic [15:0] a;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [3:0]  irq;
    logic [3:0]  en;
    logic [31:0] exp_claim;
  } pri_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    addr = a;
    read_enable = 1'b1;
    tick();
    d = data_out;
    read_enable = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a;
    data_in = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic wait_cpu_irq(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (cpu_irq) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Claim, EOI and ack for one expected ID; the source then drops its level.
  task automatic serve(input int id, input string name);
    logic [31:0] d;
    bus_read(C_ADDR_CLAIM, d);
    check({name, "_claim"}, d, 32'h8000_0000 | 32'(id));
    bus_write(C_ADDR_EOI, 32'(id));
    check({name, "_ack"}, 32'(irq_ack), 32'(1) << id);
    model_serviced = model_serviced + 16'd1;
    irq_drv[id] = 1'b0;
  endtask

  initial begin
    reg_vec_t    reset_tab [7];
    pri_vec_t    pri_tab [6];
    logic [31:0] d;
    int          lat;
    bit          seen;
    int          q[$];
    logic [3:0]  en, irq, eff;

    reset_tab[0] = '{C_ADDR_PENDING,  32'h0};
    reset_tab[1] = '{C_ADDR_ENABLE,   32'h1};
    reset_tab[2] = '{C_ADDR_CLAIM,    32'h0};
    reset_tab[3] = '{C_ADDR_EOI,      32'h0};
    reset_tab[4] = '{C_ADDR_STATUS,   32'h0};
    reset_tab[5] = '{C_ADDR_SERVICED, 32'h0};
    reset_tab[6] = '{16'h0020,        32'h0};

    pri_tab[0] = '{4'b1010, 4'hF,    32'h8000_0001};
    pri_tab[1] = '{4'b1100, 4'hF,    32'h8000_0002};
    pri_tab[2] = '{4'b1000, 4'hF,    32'h8000_0003};
    pri_tab[3] = '{4'b1110, 4'b1100, 32'h8000_0002};
    pri_tab[4] = '{4'b0110, 4'b0001, 32'h0};
    pri_tab[5] = '{4'b0001, 4'b0001, 32'h8000_0000};

    // Reset state
    repeat (3) tick();
    check("rst_cpu_irq", 32'(cpu_irq), 32'h0);
    check("rst_irq_ack", 32'(irq_ack), 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    reset_n = 1'b1;
    tick();
    foreach (reset_tab[i]) begin
      bus_read(reset_tab[i].a, d);
      check($sformatf("reset_read_%0h", reset_tab[i].a), d, reset_tab[i].exp);
    end

    // Timer loop
    timer_start = 1'b1;
    tick();
    timer_start = 1'b0;
    for (int n = 0; n < 40 && !timer_irq; n++) tick();
    check("timer_fired", 32'(timer_irq), 32'h1);
    lat = 0;
    while (!cpu_irq && lat < 5) begin
      tick();
      lat++;
    end
    check("timer_latency_le2", 32'(lat <= 2), 32'h1);
    check("timer_id", 32'(cpu_irq_id), 32'h0);
    serve(0, "timer");
    tick();
    check("timer_ack_gone", 32'(irq_ack), 32'h0);
    check("timer_irq_low", 32'(timer_irq), 32'h0);
    bus_read(C_ADDR_SERVICED, d);
    check("timer_serviced", d, 32'(model_serviced));
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= cpu_irq;
    end
    check("timer_no_retrigger", 32'(seen), 32'h0);

    // Priority table
    foreach (pri_tab[i]) begin
      bus_write(C_ADDR_ENABLE, 32'(pri_tab[i].en));
      irq_drv = pri_tab[i].irq;
      repeat (3) tick();
      bus_read(C_ADDR_CLAIM, d);
      check($sformatf("pri_claim_%0d", i), d, pri_tab[i].exp_claim);
      if (pri_tab[i].exp_claim[31]) begin
        bus_write(C_ADDR_EOI, 32'(pri_tab[i].exp_claim[ID_W-1:0]));
        model_serviced = model_serviced + 16'd1;
      end
      irq_drv = '0;
      repeat (4) tick();
    end

    // Simultaneous 1 and 3: 1 first, then 3
    bus_write(C_ADDR_ENABLE, 32'hF);
    irq_drv = 4'b1010;
    wait_cpu_irq("seq_wait1");
    serve(1, "seq_first");
    wait_cpu_irq("seq_wait3");
    check("seq_id3", 32'(cpu_irq_id), 32'h3);
    serve(3, "seq_second");
    repeat (3) tick();

    // Withdrawal
    irq_drv[2] = 1'b1;
    seen = 1'b0;
    lat = 0;
    repeat (3) begin
      tick();
      if (cpu_irq) lat = 1;
      seen |= |irq_ack;
    end
    irq_drv[2] = 1'b0;
    repeat (4) begin
      tick();
      seen |= |irq_ack;
    end
    check("wd_was_asserted", 32'(lat), 32'h1);
    check("wd_cpu_irq_low", 32'(cpu_irq), 32'h0);
    check("wd_no_ack", 32'(seen), 32'h0);
    bus_read(C_ADDR_STATUS, d);
    check("wd_status_idle", 32'(d[1:0]), 32'h0);

    // Wrong EOI
    irq_drv = 4'b0010;
    wait_cpu_irq("bad_wait");
    bus_read(C_ADDR_CLAIM, d);
    check("bad_claim", d, 32'h8000_0001);
    bus_write(C_ADDR_EOI, 32'h2);
    check("bad_no_ack", 32'(irq_ack), 32'h0);
    bus_read(C_ADDR_STATUS, d);
    check("bad_status", d, 32'h0000_0102);
    bus_write(C_ADDR_EOI, 32'h1);
    check("bad_good_ack", 32'(irq_ack), 32'h2);
    model_serviced = model_serviced + 16'd1;
    irq_drv = '0;
    repeat (3) tick();

    // Randomized service sequences against an ascending-index order model
    for (int it = 0; it < 30; it++) begin
      en  = 4'($urandom_range(1, 15));
      irq = 4'($urandom_range(0, 15));
      bus_write(C_ADDR_ENABLE, 32'(en));
      irq_drv = irq;
      eff = irq & en;
      q.delete();
      for (int b = 0; b < NUM_IRQ; b++) if (eff[b]) q.push_back(b);
      while (q.size() > 0) begin
        int id;
        id = q.pop_front();
        wait_cpu_irq("rnd_wait");
        check("rnd_id", 32'(cpu_irq_id), 32'(id));
        serve(id, "rnd");
      end
      seen = 1'b0;
      repeat (4) begin
        tick();
        seen |= cpu_irq;
      end
      check("rnd_quiet", 32'(seen), 32'h0);
      irq_drv = '0;
      repeat (3) tick();
    end
    bus_read(C_ADDR_SERVICED, d);
    check("rnd_serviced", d, 32'(model_serviced));

    // Counter wrap
    bus_write(C_ADDR_ENABLE, 32'h1);
    force dut.r_serviced = 16'hFFFF;
    #1;
    release dut.r_serviced;
    model_serviced = 16'hFFFF;
    bus_read(C_ADDR_SERVICED, d);
    check("wrap_preload", d, 32'h0000_FFFF);
    irq_drv = 4'b0001;
    wait_cpu_irq("wrap_wait");
    serve(0, "wrap");
    tick();
    bus_read(C_ADDR_SERVICED, d);
    check("wrap_serviced", d, 32'(model_serviced));

    // Reset during SERVICE
    bus_write(C_ADDR_ENABLE, 32'hF);
    irq_drv = 4'b0100;
    wait_cpu_irq("rst_wait");
    bus_read(C_ADDR_CLAIM, d);
    check("rst_claim", d, 32'h8000_0002);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstm_cpu_irq", 32'(cpu_irq), 32'h0);
    check("rstm_irq_ack", 32'(irq_ack), 32'h0);
    check("rstm_data_out", data_out, 32'h0);
    check("rstm_id", 32'(cpu_irq_id), 32'h0);
    irq_drv = '0;
    seen = 1'b0;
    repeat (2) begin
      tick();
      seen |= |irq_ack;
    end
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      seen |= |irq_ack;
    end
    check("rstm_no_ack", 32'(seen), 32'h0);
    model_serviced = 16'h0;
    bus_read(C_ADDR_ENABLE, d);
    check("rstm_enable", d, 32'h1);
    bus_read(C_ADDR_STATUS, d);
    check("rstm_status", d, 32'h0);
    bus_read(C_ADDR_SERVICED, d);
    check("rstm_serviced", d, 32'(model_serviced));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
